// File: rtl/interleave_buffer.sv
// -----------------------------------------------------------------------------
// interleave_buffer
//   Ping-pong bit buffer placed after the turbo interleaver address path.
//   The write side fills one bank with a serial code block in natural order.
//   The read side empties the other bank in permuted order: it issues natural
//   read indices to the pi1 address block and uses the permuted address that
//   comes back one cycle later as the bank read address.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   in_valid    in_bit valid this cycle
//   in_sop      first bit of a block (qualified by in_valid)
//   in_bit      serial data bit
//   block_size  block length K, sampled on the accepted sop beat
//   in_ready    write side can accept a beat
//   rd_index    natural-order read index to pi1
//   pi_addr     permuted address from pi1, valid one cycle after rd_index
//   out_valid   out_bit valid
//   out_sop     first interleaved bit of a block
//   out_eop     last interleaved bit of a block
//   out_bit     interleaved data bit
//   size_err    one-cycle pulse: sop accepted with an illegal K
// -----------------------------------------------------------------------------
module interleave_buffer #(
   parameter int ADDR_W = 13,
   parameter int DEPTH  = 6144,
   parameter int K_MIN  = 40
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic              in_sop,
   input  logic              in_bit,
   input  logic [ADDR_W-1:0] block_size,
   output logic              in_ready,
   output logic [ADDR_W-1:0] rd_index,
   input  logic [ADDR_W-1:0] pi_addr,
   output logic              out_valid,
   output logic              out_sop,
   output logic              out_eop,
   output logic              out_bit,
   output logic              size_err
);

   localparam logic [ADDR_W-1:0] K_MIN_A = ADDR_W'(K_MIN);
   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
   localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } rd_state_t;

   // storage
   logic mem [0:1][0:DEPTH-1];

   // write side
   logic [1:0]        full;
   logic              wr_bank;
   logic              wr_active;
   logic [ADDR_W-1:0] wr_cnt;
   logic [ADDR_W-1:0] ksize [0:1];

   logic              accept;
   logic              k_legal;
   logic              sop_ok;
   logic              sop_bad;
   logic              beat_wr;
   logic              fill;
   logic              we;
   logic [ADDR_W-1:0] waddr;

   // read side
   rd_state_t         state;
   rd_state_t         next_state;
   logic              rd_bank;
   logic [ADDR_W-1:0] rd_cnt;
   logic [ADDR_W-1:0] rd_last;
   logic              flush_cnt;
   logic              clear_full;
   logic              start_run;
   logic              s1_valid;
   logic              s1_sop;
   logic              s1_eop;

   // ---------------------------------------------------------------------------
   // Write-side decode
   // ---------------------------------------------------------------------------
   always_comb begin
      in_ready = ~full[wr_bank];
      accept   = in_valid & in_ready;
      k_legal  = (block_size >= K_MIN_A) && (block_size <= DEPTH_A);
      sop_ok   = accept & in_sop & k_legal;
      sop_bad  = accept & in_sop & ~k_legal;
      beat_wr  = accept & ~in_sop & wr_active;
      fill     = beat_wr & (wr_cnt == (ksize[wr_bank] - ONE));
      we       = sop_ok | beat_wr;
      waddr    = sop_ok ? '0 : wr_cnt;
   end

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_bank][waddr] <= in_bit;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         full      <= '0;
         wr_bank   <= 1'b0;
         wr_active <= 1'b0;
         wr_cnt    <= '0;
         ksize[0]  <= '0;
         ksize[1]  <= '0;
         size_err  <= 1'b0;
      end else begin
         size_err <= sop_bad;
         if (sop_ok) begin
            // a sop mid-block simply restarts the same bank
            ksize[wr_bank] <= block_size;
            wr_cnt         <= ONE;
            wr_active      <= 1'b1;
         end else if (sop_bad) begin
            wr_active <= 1'b0;
         end else if (beat_wr) begin
            if (fill) begin
               full[wr_bank] <= 1'b1;
               wr_bank       <= ~wr_bank;
               wr_cnt        <= '0;
               wr_active     <= 1'b0;
            end else begin
               wr_cnt <= wr_cnt + ONE;
            end
         end
         // fill only targets a non-full bank and clear only a full one,
         // so the two updates never touch the same bit
         if (clear_full) begin
            full[rd_bank] <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Read FSM
   // ---------------------------------------------------------------------------
   assign rd_last  = ksize[rd_bank] - ONE;
   assign rd_index = rd_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      clear_full = 1'b0;
      start_run  = 1'b0;
      case (state)
         IDLE: begin
            // a bank being filled this very cycle counts as full, so the
            // read starts on the cycle right after the last write beat
            if (full[rd_bank] | (fill & (wr_bank == rd_bank))) begin
               next_state = RUN;
               start_run  = 1'b1;
            end
         end
         RUN: begin
            if (rd_cnt == rd_last) begin
               next_state = FLUSH;
            end
         end
         FLUSH: begin
            if (flush_cnt) begin
               next_state = IDLE;
               clear_full = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_bank   <= 1'b0;
         rd_cnt    <= '0;
         flush_cnt <= 1'b0;
         s1_valid  <= 1'b0;
         s1_sop    <= 1'b0;
         s1_eop    <= 1'b0;
         out_valid <= 1'b0;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
         out_bit   <= 1'b0;
      end else begin
         if (start_run) begin
            rd_cnt <= '0;
         end else if ((state == RUN) && (next_state == RUN)) begin
            rd_cnt <= rd_cnt + ONE;
         end

         flush_cnt <= (state == FLUSH) ? ~flush_cnt : 1'b0;

         if (clear_full) begin
            rd_bank <= ~rd_bank;
         end

         // stage 1: index issued; pi_addr arrives next cycle
         s1_valid <= (state == RUN);
         s1_sop   <= (state == RUN) && (rd_cnt == '0);
         s1_eop   <= (state == RUN) && (rd_cnt == rd_last);

         // stage 2: registered bank read at the permuted address
         out_valid <= s1_valid;
         out_sop   <= s1_sop;
         out_eop   <= s1_eop;
         out_bit   <= s1_valid & mem[rd_bank][pi_addr];
      end
   end

endmodule

// File: doc/interleave_buffer.md
Name: interleave_buffer

Overview:
- Ping-pong bit buffer directly downstream of the turbo interleaver address path.
- Write side: collects a serial input code block into one bank at natural-order addresses.
- Read side: reads the other bank out in permuted order, using the permutation address returned by the pi1 address block for each read index this block issues.
- Output is the interleaved bit stream with framing strobes for the constituent-encoder stage.

Parameters:
- ADDR_W, 13, width of bit addresses, read indices and block size.
- DEPTH, 6144, bits per bank (largest code block).
- K_MIN, 40, smallest legal block size.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_bit is valid this cycle.
- in_sop  input  1  first bit of a block; qualified by in_valid.
- in_bit  input  1  serial data bit.
- block_size  input  ADDR_W  block length K; sampled on the accepted sop beat.
- in_ready  output  1  write side can accept a beat.
- rd_index  output  ADDR_W  natural-order read index driven to the pi1 block.
- pi_addr  input  ADDR_W  permuted address from pi1; valid exactly 1 cycle after rd_index.
- out_valid  output  1  out_bit is valid.
- out_sop  output  1  first interleaved bit of a block.
- out_eop  output  1  last interleaved bit of a block.
- out_bit  output  1  interleaved data bit.
- size_err  output  1  one-cycle pulse: sop accepted with K < K_MIN or K > DEPTH.

Behaviour:
- Reset values (asserted or mid-operation): all outputs 0 except in_ready=1; both banks empty; wr_bank=0; rd_bank=0; write side inactive; read FSM IDLE. Memory contents don't-care; any block in flight is discarded.
- Storage: two banks of DEPTH x 1 bit; synchronous write; registered read.
- Write side:
  - Beat accepted = in_valid & in_ready.
  - in_ready = !full[wr_bank] (registered flag).
  - Accepted sop beat: latch K into ksize[wr_bank], write bit to address 0, wr_cnt <= 1, write side active.
  - Sop with illegal K: pulse size_err, go inactive, write nothing.
  - Accepted non-sop beat while inactive: ignored.
  - While active: write at wr_cnt, then increment.
  - Beat written at address K-1: set full[wr_bank], toggle wr_bank, wr_cnt <= 0, go inactive.
  - Sop mid-block: partial block abandoned; restart at address 0 in the same bank with the new K.
- Read FSM, states IDLE, RUN, FLUSH:
  - IDLE: when full[rd_bank]=1 -> RUN with rd_cnt=0.
  - RUN: drive rd_index=rd_cnt, increment every cycle. After issuing K-1 -> FLUSH. rd_index holds its last value outside RUN.
  - FLUSH: 2 cycles to drain the pipeline. Then clear full[rd_bank], toggle rd_bank, return to IDLE.
- Read pipeline:
  - Cycle t: rd_index issued.
  - Cycle t+1: pi_addr sampled as the bank read address.
  - Cycle t+2: out_bit, out_valid=1.
  - out_sop marks the bit for index 0; out_eop marks the bit for index K-1.
  - Latency from rd_index to out_bit is 2 cycles; output is gap-free within a block.
- Back-to-back blocks: minimum gap between consecutive output blocks is 3 cycles (FLUSH plus IDLE).
- Simultaneous events:
  - Read clearing full on bank X in the same cycle write is blocked on X: in_ready rises the next cycle.
  - Write filling bank Y while read is IDLE on Y: RUN starts the next cycle.
- pi_addr >= K is not checked; the bank contents at that address are output.
- No output backpressure.

Test Plan:
- K=40, in_bit = index parity, pi1 model = identity, no gaps -> RUN starts 1 cycle after the 40th beat; 40 output bits equal the input sequence; out_sop on the first, out_eop on the 40th; out_valid begins 2 cycles after rd_index=0.
- K=40, pi_addr = (3*i) mod 40 model, random bits -> out_bit[i] = in_bit[(3*i) mod 40] for all i.
- Three K=6144 blocks streamed continuously -> in_ready drops after the second block is written and rises the cycle after the first read block's FLUSH ends; all three blocks emerge correct and in order.
- Sop at beat 20 of a K=100 block, followed by a full K=40 block -> only the 40-bit block is output; size_err stays 0.
- Sop with K=39, then K=6145 -> size_err pulses once for each; following data beats produce no output.
- Reset asserted mid-read at index 1000 of K=6144 -> outputs go to 0 and in_ready to 1 asynchronously; after release, a new K=40 block passes correctly.
